rx_cmd_sequencer: RTL and testbench
===================================

RX_CMD_SEQUENCER -- requirements
Module: RX_CMD_SEQUENCER

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 8, width of a UART frame byte and a register-file word.
REQ-002 SHALL have parameter ADDR_WIDTH, 4, width of the register-file address.
REQ-003 SHALL have parameter TIMEOUT, 255, maximum number of wait cycles for a read or ALU response.
REQ-004 SHALL have port clk  in  1  the only clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports RX_P_DATA  in  DATA_WIDTH  byte from UART RX, and RX_D_VLD  in  1  one-cycle strobe marking RX_P_DATA valid, already synchronized to clk.
REQ-007 SHALL have ports RD_DATA  in  DATA_WIDTH  and RD_DATA_VLD  in  1  for the register-file read response.
REQ-008 SHALL have ports ALU_OUT  in  2*DATA_WIDTH  and ALU_OUT_VLD  in  1  for the ALU result.
REQ-009 SHALL have port FIFO_FULL  in  1  meaning the TX FIFO is full.
REQ-010 SHALL have register-file outputs WR_EN  out  1, RD_EN  out  1, ADDRESS  out  ADDR_WIDTH and WR_DATA  out  DATA_WIDTH.
REQ-011 SHALL have ALU outputs ALU_EN  out  1, ALU_FUN  out  4 and CLK_GATE_EN  out  1.
REQ-012 SHALL have TX outputs TX_P_DATA  out  DATA_WIDTH and TX_D_VLD  out  1, plus FRAME_ERR  out  1, a one-cycle error pulse.

Function
REQ-013 SHALL decode the first byte in IDLE as a command: 0xAA = register write, 0xBB = register read, 0xCC = ALU with operands, 0xDD = ALU without operands.
REQ-014 SHALL keep any other first byte out of every state transition, remain in IDLE, and pulse FRAME_ERR the next cycle.
REQ-015 SHALL use the states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN_S, ALU_WAIT, TX_LO and TX_HI.
REQ-016 SHALL advance through the byte-collecting states (WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN_S) only on cycles where RX_D_VLD=1.
REQ-017 SHALL sequence a write as 0xAA -> WR_ADDR; on the address byte, latch RX_P_DATA[ADDR_WIDTH-1:0] -> WR_DATA; on the data byte, WR_EN=1 for exactly one cycle in the following cycle, with the latched ADDRESS and WR_DATA=data byte -> IDLE.
REQ-018 SHALL sequence a read as 0xBB -> RD_ADDR; on the address byte, RD_EN=1 for one cycle in the following cycle, with ADDRESS=addr -> RD_WAIT; on RD_DATA_VLD, latch RD_DATA -> TX_LO.
REQ-019 SHALL sequence 0xCC as OP_A (write that byte to address 0x0 using the REQ-017 timing) -> OP_B (write to address 0x1) -> ALU_FUN_S; 0xDD SHALL go directly to ALU_FUN_S.
REQ-020 SHALL, in ALU_FUN_S, latch RX_P_DATA[3:0] into ALU_FUN on the function byte -> ALU_WAIT.
REQ-021 SHALL hold ALU_EN=1 and CLK_GATE_EN=1 from the cycle after the function byte until and including the cycle where ALU_OUT_VLD=1, then latch ALU_OUT -> TX_LO.
REQ-022 SHALL, in TX_LO, drive TX_P_DATA and pulse TX_D_VLD for one cycle in the first cycle where FIFO_FULL=0.
REQ-023 SHALL send the read byte from TX_LO and then return to IDLE.
REQ-024 SHALL, for ALU results, send ALU_OUT[7:0] from TX_LO, then ALU_OUT[15:8] from TX_HI using the same FIFO_FULL rule, then return to IDLE.
REQ-025 SHALL, while FIFO_FULL=1, hold the state and hold TX_P_DATA stable with TX_D_VLD=0.
REQ-026 SHALL run a watchdog counter in RD_WAIT and ALU_WAIT: clear it on state entry and increment it each cycle.
REQ-027 SHALL, when the watchdog reaches TIMEOUT without a valid, go to IDLE, pulse FRAME_ERR, and drop ALU_EN and CLK_GATE_EN.
REQ-028 SHALL let the valid win when it arrives in the same cycle the watchdog expires.
REQ-029 SHALL ignore and discard RX_D_VLD bytes in RD_WAIT, ALU_WAIT, TX_LO and TX_HI, with no FRAME_ERR.
REQ-030 SHALL never assert WR_EN and RD_EN in the same cycle, and SHALL assert TX_D_VLD at most once per byte.

Reset
REQ-031 SHALL, while rst=0, force the state to IDLE, clear the watchdog and latched data, and drive every output to 0, including ALU_FUN, ADDRESS, WR_DATA and TX_P_DATA.
REQ-032 SHALL make a reset asserted mid-frame discard the partial frame; after rst is released, the next byte is decoded as a command.

Verification
REQ-033 SHALL pass: bytes 0xAA, 0x05, 0x3C -> one WR_EN pulse with ADDRESS=0x5, WR_DATA=0x3C, then IDLE.
REQ-034 SHALL pass: bytes 0xBB, 0x02; RD_DATA=0x7E, RD_DATA_VLD after 3 cycles; FIFO_FULL=0 -> one RD_EN with ADDRESS=0x2, then one TX_D_VLD with TX_P_DATA=0x7E.
REQ-035 SHALL pass: bytes 0xCC, 0x10, 0x20, 0x00; ALU_OUT=0x0030 -> WR_EN to 0x0=0x10 and to 0x1=0x20, ALU_FUN=0x0, ALU_EN held until valid, then TX bytes 0x30, 0x00.
REQ-036 SHALL pass: bytes 0xDD, 0x02; FIFO_FULL=1 for 10 cycles after ALU_OUT_VLD -> no TX_D_VLD while full, bytes sent in order once FIFO_FULL=0.
REQ-037 SHALL pass: byte 0x55 -> FRAME_ERR pulse with the state kept at IDLE; bytes 0xBB, 0x01 with no RD_DATA_VLD -> FRAME_ERR at TIMEOUT and return to IDLE.
REQ-038 SHALL pass: rst=0 asserted in the middle of the ALU_WAIT wait -> all outputs 0 immediately; after release, bytes 0xAA, 0x01, 0xFF -> a correct write.

Source files
------------

// File: rtl/rx_cmd_sequencer.sv
// Command sequencer between a UART RX byte stream, a register file, an ALU and a TX FIFO.
// Frames: AA addr data | BB addr | CC opA opB fun | DD fun; results are returned LSB first.
module rx_cmd_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]     RD_DATA,
    input  logic                      RD_DATA_VLD,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VLD,
    input  logic                      FIFO_FULL,
    output logic                      WR_EN,
    output logic                      RD_EN,
    output logic [ADDR_WIDTH-1:0]     ADDRESS,
    output logic [DATA_WIDTH-1:0]     WR_DATA,
    output logic                      ALU_EN,
    output logic [3:0]                ALU_FUN,
    output logic                      CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    output logic                      FRAME_ERR
);

    // state      | meaning
    // S_IDLE     | waiting for a command byte
    // S_WR_*     | collecting write address / data
    // S_RD_*     | collecting read address / waiting for read response
    // S_OP_A/B   | collecting ALU operands (written to regs 0 and 1)
    // S_ALU_FUN  | collecting ALU function; S_ALU_WAIT waits for the result
    // S_TX_LO/HI | pushing result bytes into the TX FIFO
    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_OP_A,
        S_OP_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_TX_LO,
        S_TX_HI
    } state_t;

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

    state_t                    state, state_nxt;
    logic [WD_W-1:0]           wd, wd_nxt;
    logic [2*DATA_WIDTH-1:0]   result, result_nxt;
    logic                      two_bytes, two_bytes_nxt;
    logic                      wd_expired;

    logic                      wr_en_nxt;
    logic                      rd_en_nxt;
    logic [ADDR_WIDTH-1:0]     address_nxt;
    logic [DATA_WIDTH-1:0]     wr_data_nxt;
    logic                      alu_en_nxt;
    logic [3:0]                alu_fun_nxt;
    logic                      clk_gate_en_nxt;
    logic [DATA_WIDTH-1:0]     tx_data_nxt;
    logic                      tx_vld_nxt;
    logic                      frame_err_nxt;

    // The TIMEOUT-th wait cycle is the last one; a valid in that cycle still wins.
    assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt       = state;
        wd_nxt          = wd;
        result_nxt      = result;
        two_bytes_nxt   = two_bytes;
        wr_en_nxt       = 1'b0;
        rd_en_nxt       = 1'b0;
        address_nxt     = ADDRESS;
        wr_data_nxt     = WR_DATA;
        alu_en_nxt      = ALU_EN;
        alu_fun_nxt     = ALU_FUN;
        clk_gate_en_nxt = CLK_GATE_EN;
        tx_data_nxt     = TX_P_DATA;
        tx_vld_nxt      = 1'b0;
        frame_err_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:     state_nxt = S_WR_ADDR;
                        CMD_RD:     state_nxt = S_RD_ADDR;
                        CMD_ALU_OP: state_nxt = S_OP_A;
                        CMD_ALU:    state_nxt = S_ALU_FUN;
                        default:    frame_err_nxt = 1'b1;
                    endcase
                end
            end
            S_WR_ADDR: begin
                if (RX_D_VLD) begin
                    address_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_nxt   = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_nxt   = 1'b1;
                    wr_data_nxt = RX_P_DATA;
                    state_nxt   = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    address_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_nxt   = 1'b1;
                    wd_nxt      = '0;
                    state_nxt   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (RD_DATA_VLD) begin
                    result_nxt    = {{DATA_WIDTH{1'b0}}, RD_DATA};
                    two_bytes_nxt = 1'b0;
                    state_nxt     = S_TX_LO;
                end else if (wd_expired) begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end else begin
                    wd_nxt = wd + WD_W'(1);
                end
            end
            S_OP_A: begin
                if (RX_D_VLD) begin
                    wr_en_nxt   = 1'b1;
                    address_nxt = '0;
                    wr_data_nxt = RX_P_DATA;
                    state_nxt   = S_OP_B;
                end
            end
            S_OP_B: begin
                if (RX_D_VLD) begin
                    wr_en_nxt   = 1'b1;
                    address_nxt = ADDR_WIDTH'(1);
                    wr_data_nxt = RX_P_DATA;
                    state_nxt   = S_ALU_FUN;
                end
            end
            S_ALU_FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_nxt     = RX_P_DATA[3:0];
                    alu_en_nxt      = 1'b1;
                    clk_gate_en_nxt = 1'b1;
                    wd_nxt          = '0;
                    state_nxt       = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    alu_en_nxt      = 1'b0;
                    clk_gate_en_nxt = 1'b0;
                    result_nxt      = ALU_OUT;
                    two_bytes_nxt   = 1'b1;
                    state_nxt       = S_TX_LO;
                end else if (wd_expired) begin
                    alu_en_nxt      = 1'b0;
                    clk_gate_en_nxt = 1'b0;
                    frame_err_nxt   = 1'b1;
                    state_nxt       = S_IDLE;
                end else begin
                    wd_nxt = wd + WD_W'(1);
                end
            end
            S_TX_LO: begin
                if (!FIFO_FULL) begin
                    tx_data_nxt = result[DATA_WIDTH-1:0];
                    tx_vld_nxt  = 1'b1;
                    state_nxt   = two_bytes ? S_TX_HI : S_IDLE;
                end
            end
            S_TX_HI: begin
                if (!FIFO_FULL) begin
                    tx_data_nxt = result[2*DATA_WIDTH-1:DATA_WIDTH];
                    tx_vld_nxt  = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            wd          <= '0;
            result      <= '0;
            two_bytes   <= 1'b0;
            WR_EN       <= 1'b0;
            RD_EN       <= 1'b0;
            ADDRESS     <= '0;
            WR_DATA     <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            FRAME_ERR   <= 1'b0;
        end else begin
            state       <= state_nxt;
            wd          <= wd_nxt;
            result      <= result_nxt;
            two_bytes   <= two_bytes_nxt;
            WR_EN       <= wr_en_nxt;
            RD_EN       <= rd_en_nxt;
            ADDRESS     <= address_nxt;
            WR_DATA     <= wr_data_nxt;
            ALU_EN      <= alu_en_nxt;
            ALU_FUN     <= alu_fun_nxt;
            CLK_GATE_EN <= clk_gate_en_nxt;
            TX_P_DATA   <= tx_data_nxt;
            TX_D_VLD    <= tx_vld_nxt;
            FRAME_ERR   <= frame_err_nxt;
        end
    end

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Directed bench for rx_cmd_sequencer: vector tables for write/read/bad-command frames,
// hand-written sequences for ALU, FIFO back-pressure, watchdog and mid-frame reset.
module tb_rx_cmd_sequencer;

    localparam int DW      = 8;
    localparam int AW      = 4;
    localparam int TIMEOUT = 255;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DW-1:0]   RX_P_DATA = '0;
    logic            RX_D_VLD = 1'b0;
    logic [DW-1:0]   RD_DATA = '0;
    logic            RD_DATA_VLD = 1'b0;
    logic [2*DW-1:0] ALU_OUT = '0;
    logic            ALU_OUT_VLD = 1'b0;
    logic            FIFO_FULL = 1'b0;
    logic            WR_EN, RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD, FRAME_ERR;
    logic [AW-1:0]   ADDRESS;
    logic [DW-1:0]   WR_DATA, TX_P_DATA;
    logic [3:0]      ALU_FUN;

    rx_cmd_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RD_DATA(RD_DATA), .RD_DATA_VLD(RD_DATA_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .FIFO_FULL(FIFO_FULL),
        .WR_EN(WR_EN), .RD_EN(RD_EN), .ADDRESS(ADDRESS), .WR_DATA(WR_DATA),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FRAME_ERR(FRAME_ERR)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int fe_cnt = 0;
    int overlap_cnt = 0;
    logic [DW-1:0] tx_q[$];

    // Sampled at posedge: sees the value held during the cycle just ending.
    always @(posedge clk) begin
        if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
        if (FRAME_ERR) fe_cnt++;
        if (WR_EN && RD_EN) overlap_cnt++;
    end

    typedef struct {
        logic [7:0] addr_b;
        logic [7:0] data_b;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
    } wr_vec_t;

    typedef struct {
        logic [7:0] addr_b;
        logic [7:0] rd_data;
        int         delay;
        logic [3:0] exp_addr;
        logic [7:0] exp_tx;
    } rd_vec_t;

    typedef struct {
        logic [7:0] cmd;
        logic       exp_fe;
    } err_vec_t;

    wr_vec_t  wr_tab[3];
    rd_vec_t  rd_tab[2];
    err_vec_t err_tab[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge clk);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] all_outs();
        return {2'b00, WR_EN, RD_EN, ADDRESS, WR_DATA, ALU_EN, ALU_FUN,
                CLK_GATE_EN, TX_P_DATA, TX_D_VLD, FRAME_ERR};
    endfunction

    task automatic do_write(input string tag, input logic [7:0] a, input logic [7:0] d,
                            input logic [3:0] ea, input logic [7:0] ed);
        send_byte(8'hAA);
        send_byte(a);
        send_byte(d);
        check({tag, "_wr_en"}, 32'(WR_EN), 32'd1);
        check({tag, "_rd_en"}, 32'(RD_EN), 32'd0);
        check({tag, "_addr"}, 32'(ADDRESS), 32'(ea));
        check({tag, "_data"}, 32'(WR_DATA), 32'(ed));
        @(negedge clk);
        check({tag, "_wr_en_pulse"}, 32'(WR_EN), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int fe_before;
        int n_hi;

        wr_tab[0] = '{addr_b: 8'h05, data_b: 8'h3C, exp_addr: 4'h5, exp_data: 8'h3C};
        wr_tab[1] = '{addr_b: 8'h1F, data_b: 8'hFF, exp_addr: 4'hF, exp_data: 8'hFF};
        wr_tab[2] = '{addr_b: 8'h00, data_b: 8'hAA, exp_addr: 4'h0, exp_data: 8'hAA};

        rd_tab[0] = '{addr_b: 8'h02, rd_data: 8'h7E, delay: 3, exp_addr: 4'h2, exp_tx: 8'h7E};
        rd_tab[1] = '{addr_b: 8'hBF, rd_data: 8'hA5, delay: 0, exp_addr: 4'hF, exp_tx: 8'hA5};

        err_tab[0] = '{cmd: 8'h55, exp_fe: 1'b1};
        err_tab[1] = '{cmd: 8'h00, exp_fe: 1'b1};
        err_tab[2] = '{cmd: 8'hAB, exp_fe: 1'b1};

        // Reset state
        idle(3);
        check("reset_outputs", all_outs(), 32'd0);
        rst = 1'b1;
        idle(2);
        check("post_reset_outputs", all_outs(), 32'd0);

        // Register writes
        for (int i = 0; i < 3; i++) begin
            do_write($sformatf("wr%0d", i), wr_tab[i].addr_b, wr_tab[i].data_b,
                     wr_tab[i].exp_addr, wr_tab[i].exp_data);
        end

        // Bad command bytes: one-cycle FRAME_ERR, FSM stays in IDLE
        for (int i = 0; i < 3; i++) begin
            send_byte(err_tab[i].cmd);
            check($sformatf("err%0d_fe", i), 32'(FRAME_ERR), 32'(err_tab[i].exp_fe));
            @(negedge clk);
            check($sformatf("err%0d_fe_pulse", i), 32'(FRAME_ERR), 32'd0);
            do_write($sformatf("err%0d_next", i), 8'h03, 8'h44, 4'h3, 8'h44);
        end

        // Register reads
        for (int i = 0; i < 2; i++) begin
            idle(2);
            tx_q.delete();
            fe_before = fe_cnt;
            send_byte(8'hBB);
            send_byte(rd_tab[i].addr_b);
            check($sformatf("rd%0d_rd_en", i), 32'(RD_EN), 32'd1);
            check($sformatf("rd%0d_wr_en", i), 32'(WR_EN), 32'd0);
            check($sformatf("rd%0d_addr", i), 32'(ADDRESS), 32'(rd_tab[i].exp_addr));
            if (rd_tab[i].delay > 0) begin
                send_byte(8'hAA);  // stray byte while waiting is discarded
                idle(rd_tab[i].delay - 1);
            end
            RD_DATA = rd_tab[i].rd_data;
            RD_DATA_VLD = 1'b1;
            @(negedge clk);
            RD_DATA_VLD = 1'b0;
            RD_DATA = 8'h00;
            idle(5);
            check($sformatf("rd%0d_tx_count", i), 32'(tx_q.size()), 32'd1);
            if (tx_q.size() > 0)
                check($sformatf("rd%0d_tx_data", i), 32'(tx_q[0]), 32'(rd_tab[i].exp_tx));
            check($sformatf("rd%0d_no_fe", i), 32'(fe_cnt - fe_before), 32'd0);
        end

        // ALU with operands: CC 10 20 00 -> 0x0030
        tx_q.delete();
        fe_before = fe_cnt;
        send_byte(8'hCC);
        send_byte(8'h10);
        check("cc_opa_wr_en", 32'(WR_EN), 32'd1);
        check("cc_opa_addr", 32'(ADDRESS), 32'h0);
        check("cc_opa_data", 32'(WR_DATA), 32'h10);
        send_byte(8'h20);
        check("cc_opb_wr_en", 32'(WR_EN), 32'd1);
        check("cc_opb_addr", 32'(ADDRESS), 32'h1);
        check("cc_opb_data", 32'(WR_DATA), 32'h20);
        check("cc_alu_en_early", 32'(ALU_EN), 32'd0);
        send_byte(8'h00);
        check("cc_alu_en", 32'(ALU_EN), 32'd1);
        check("cc_clk_gate", 32'(CLK_GATE_EN), 32'd1);
        check("cc_alu_fun", 32'(ALU_FUN), 32'h0);
        send_byte(8'h55);  // discarded in ALU_WAIT, no error
        n_hi = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (ALU_EN && CLK_GATE_EN) n_hi++;
        end
        check("cc_alu_en_held", 32'(n_hi), 32'd3);
        ALU_OUT = 16'h0030;
        ALU_OUT_VLD = 1'b1;
        @(negedge clk);
        ALU_OUT_VLD = 1'b0;
        ALU_OUT = 16'hFFFF;
        check("cc_alu_en_drop", 32'({ALU_EN, CLK_GATE_EN}), 32'd0);
        idle(5);
        check("cc_tx_count", 32'(tx_q.size()), 32'd2);
        if (tx_q.size() == 2) begin
            check("cc_tx_lo", 32'(tx_q[0]), 32'h30);
            check("cc_tx_hi", 32'(tx_q[1]), 32'h00);
        end
        check("cc_no_fe", 32'(fe_cnt - fe_before), 32'd0);

        // ALU without operands under TX FIFO back-pressure
        tx_q.delete();
        send_byte(8'hDD);
        send_byte(8'h02);
        check("dd_alu_fun", 32'(ALU_FUN), 32'h2);
        check("dd_no_wr", 32'(WR_EN), 32'd0);
        FIFO_FULL = 1'b1;
        @(negedge clk);
        ALU_OUT = 16'hBEEF;
        ALU_OUT_VLD = 1'b1;
        @(negedge clk);
        ALU_OUT_VLD = 1'b0;
        ALU_OUT = 16'h0000;
        idle(9);
        check("dd_full_no_tx", 32'(tx_q.size()), 32'd0);
        check("dd_full_vld_low", 32'(TX_D_VLD), 32'd0);
        FIFO_FULL = 1'b0;
        idle(5);
        check("dd_tx_count", 32'(tx_q.size()), 32'd2);
        if (tx_q.size() == 2) begin
            check("dd_tx_lo", 32'(tx_q[0]), 32'hEF);
            check("dd_tx_hi", 32'(tx_q[1]), 32'hBE);
        end

        // Read watchdog expiry
        fe_before = fe_cnt;
        send_byte(8'hBB);
        send_byte(8'h01);
        check("to_rd_en", 32'(RD_EN), 32'd1);
        k = 0;
        for (int c = 1; c <= 2 * TIMEOUT; c++) begin
            @(negedge clk);
            if (FRAME_ERR) begin
                k = c;
                break;
            end
        end
        check("to_rd_cycles", 32'(k), 32'(TIMEOUT));
        @(negedge clk);
        check("to_rd_fe_pulse", 32'(FRAME_ERR), 32'd0);
        do_write("to_rd_next", 8'h07, 8'h99, 4'h7, 8'h99);

        // Valid arriving in the expiry cycle wins
        tx_q.delete();
        send_byte(8'hBB);
        send_byte(8'h03);
        idle(TIMEOUT - 1);
        RD_DATA = 8'h5A;
        RD_DATA_VLD = 1'b1;
        @(negedge clk);
        RD_DATA_VLD = 1'b0;
        check("vw_no_fe", 32'(FRAME_ERR), 32'd0);
        idle(4);
        check("vw_tx_count", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() == 1) check("vw_tx_data", 32'(tx_q[0]), 32'h5A);

        // ALU watchdog expiry drops the enables
        send_byte(8'hDD);
        send_byte(8'h01);
        k = 0;
        for (int c = 1; c <= 2 * TIMEOUT; c++) begin
            @(negedge clk);
            if (FRAME_ERR) begin
                k = c;
                break;
            end
        end
        check("to_alu_cycles", 32'(k), 32'(TIMEOUT));
        check("to_alu_en_drop", 32'({ALU_EN, CLK_GATE_EN}), 32'd0);
        idle(2);
        check("total_fe", 32'(fe_cnt - fe_before), 32'd2);

        // Reset in the middle of ALU_WAIT
        send_byte(8'hDD);
        send_byte(8'h03);
        idle(5);
        check("rst_pre_alu_en", 32'(ALU_EN), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_outputs", all_outs(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        do_write("rst_next", 8'h01, 8'hFF, 4'h1, 8'hFF);

        check("wr_rd_overlap", 32'(overlap_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
